// File: rtl/hedios_pkg.sv
// hedios_pkg: shared widths, limits and status-word layout for the hedios action mailbox
package hedios_pkg;
  localparam int PARAM_W      = 32;
  localparam int CNT_W        = 8;
  localparam int MAX_CHANNELS = 16;
  localparam int VALID_LSB    = 0;
  localparam int OVR_LSB      = 16;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/hedios_mailbox_slot.sv
// hedios_mailbox_slot: one-entry mailbox for a single action channel with sticky overrun tracking
module hedios_mailbox_slot
  import hedios_pkg::*;
#(
  parameter int OVERWRITE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               soft_clr,
  input  logic               ovr_clear,
  input  logic               pulse,
  input  logic [PARAM_W-1:0] param,
  input  logic               ready,
  output logic               valid,
  output logic [PARAM_W-1:0] data,
  output logic               ovr
);
  slot_state_e state_q, state_d;
  logic [PARAM_W-1:0] data_q, data_d;
  logic ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic xfer, ovr_ev;
  always_comb begin
    xfer    = (state_q == FULL) && ready;
    ovr_ev  = (state_q == FULL) && pulse && !ready;
    state_d = soft_clr ? EMPTY : pulse ? FULL : xfer ? EMPTY : state_q;
    data_d  = soft_clr ? '0 : (pulse && (!ovr_ev || OVERWRITE != 0)) ? param : data_q;
    ovr_d   = soft_clr ? 1'b0 : ovr_ev ? 1'b1 : ovr_clear ? 1'b0 : ovr_q;
    // a fresh overrun beats a coincident clear and restarts the count at one
    cnt_d   = soft_clr ? '0 : ovr_ev ? (ovr_clear ? CNT_W'(1) : sat_inc(cnt_q)) : ovr_clear ? '0 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end
  assign valid = (state_q == FULL);
  assign data  = data_q;
  assign ovr   = ovr_q;
endmodule

// File: rtl/hedios_action_mailbox.sv
// hedios_action_mailbox: per-channel action mailboxes plus a registered slot-ready status word
module hedios_action_mailbox
  import hedios_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int OVERWRITE = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              soft_clr,
  input  logic [CHANNELS-1:0]               action_pulse,
  input  logic [CHANNELS-1:0][PARAM_W-1:0]  action_param,
  output logic [CHANNELS-1:0]               ch_valid,
  output logic [CHANNELS-1:0][PARAM_W-1:0]  ch_data,
  input  logic [CHANNELS-1:0]               ch_ready,
  input  logic                              ovr_clear,
  output logic [31:0]                       status_word
);
  logic [CHANNELS-1:0] ovr;
  logic [31:0] status_q, status_d;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_slot
    hedios_mailbox_slot #(.OVERWRITE(OVERWRITE)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .soft_clr  (soft_clr),
      .ovr_clear (ovr_clear),
      .pulse     (action_pulse[i]),
      .param     (action_param[i]),
      .ready     (ch_ready[i]),
      .valid     (ch_valid[i]),
      .data      (ch_data[i]),
      .ovr       (ovr[i])
    );
  end
  always_comb begin
    status_d = '0;
    status_d[VALID_LSB +: CHANNELS] = ch_valid;
    status_d[OVR_LSB +: CHANNELS]   = ovr;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) status_q <= '0;
    else      status_q <= status_d;
  end
  assign status_word = status_q;
endmodule

// File: tb/tb_hedios_action_mailbox.sv
// tb_hedios_action_mailbox: directed and random checks of both overwrite policies against a behavioural model
module tb_hedios_action_mailbox;
  localparam int C = 4;
  logic clk = 0;
  logic rst = 0;
  logic soft_clr = 0;
  logic ovr_clear = 0;
  logic [C-1:0] action_pulse = '0;
  logic [C-1:0][31:0] action_param = '0;
  logic [C-1:0] ch_ready = '0;
  logic [C-1:0] v1, v0;
  logic [C-1:0][31:0] d1, d0;
  logic [31:0] s1, s0;
  int n_chk = 0;
  int n_fail = 0;
  bit          mv [2][C];
  logic [31:0] md [2][C];
  bit          mo [2][C];
  int          mc [2][C];
  logic [31:0] ms [2];

  always #5 clk = ~clk;

  hedios_action_mailbox #(.CHANNELS(C), .OVERWRITE(1)) dut (
    .clk(clk), .rst(rst), .soft_clr(soft_clr), .action_pulse(action_pulse),
    .action_param(action_param), .ch_valid(v1), .ch_data(d1), .ch_ready(ch_ready),
    .ovr_clear(ovr_clear), .status_word(s1));
  hedios_action_mailbox #(.CHANNELS(C), .OVERWRITE(0)) dut0 (
    .clk(clk), .rst(rst), .soft_clr(soft_clr), .action_pulse(action_pulse),
    .action_param(action_param), .ch_valid(v0), .ch_data(d0), .ch_ready(ch_ready),
    .ovr_clear(ovr_clear), .status_word(s0));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ms[k] = 0;
      for (int c = 0; c < C; c++) begin
        mv[k][c] = 0; md[k][c] = 0; mo[k][c] = 0; mc[k][c] = 0;
      end
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      ms[k] = 0;
      for (int c = 0; c < C; c++) begin
        ms[k][c] = mv[k][c];
        ms[k][16+c] = mo[k][c];
      end
      for (int c = 0; c < C; c++) begin
        if (soft_clr) begin
          mv[k][c] = 0; md[k][c] = 0; mo[k][c] = 0; mc[k][c] = 0;
        end else if (action_pulse[c] && mv[k][c] && !ch_ready[c]) begin
          mo[k][c] = 1;
          mc[k][c] = ovr_clear ? 1 : (mc[k][c] < 255 ? mc[k][c] + 1 : 255);
          if (k == 1) md[k][c] = action_param[c];
        end else begin
          if (ovr_clear) begin mo[k][c] = 0; mc[k][c] = 0; end
          if (action_pulse[c]) begin md[k][c] = action_param[c]; mv[k][c] = 1; end
          else if (mv[k][c] && ch_ready[c]) mv[k][c] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < C; c++) begin
      check("valid_ow1", 32'(v1[c]), 32'(mv[1][c]));
      check("data_ow1", d1[c], md[1][c]);
      check("valid_ow0", 32'(v0[c]), 32'(mv[0][c]));
      check("data_ow0", d0[c], md[0][c]);
    end
    check("status_ow1", s1, ms[1]);
    check("status_ow0", s0, ms[0]);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    action_pulse = '0; ch_ready = '0; ovr_clear = 0; soft_clr = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("rst_cnt", 32'(dut.g_slot[0].u_slot.cnt_q), 0);
    rst = 1;
    tick();
    // basic load then consume
    action_pulse = 4'b0001; action_param[0] = 32'hDEADBEEF;
    tick();
    check("load_valid", 32'(v1[0]), 1);
    check("load_data", d1[0], 32'hDEADBEEF);
    idle(); ch_ready[0] = 1;
    tick();
    check("consume_valid", 32'(v1[0]), 0);
    check("consume_hold", d1[0], 32'hDEADBEEF);
    // overrun under both policies
    idle(); action_pulse[0] = 1; action_param[0] = 32'h1;
    tick();
    action_param[0] = 32'h2;
    tick();
    check("ovr_data_ow1", d1[0], 32'h2);
    check("ovr_data_ow0", d0[0], 32'h1);
    check("ovr_cnt_ow1", 32'(dut.g_slot[0].u_slot.cnt_q), 1);
    check("ovr_cnt_ow0", 32'(dut0.g_slot[0].u_slot.cnt_q), 1);
    idle();
    tick();
    check("ovr_status", 32'(s1[16]), 1);
    check("ovr_status0", 32'(s0[16]), 1);
    // pulse with transfer is not an overrun
    ovr_clear = 1;
    tick();
    idle(); action_pulse[0] = 1; ch_ready[0] = 1; action_param[0] = 32'h55;
    tick();
    idle();
    tick();
    check("pr_valid", 32'(v1[0]), 1);
    check("pr_data", d1[0], 32'h55);
    check("pr_ovr", 32'(s1[16]), 0);
    check("pr_cnt", 32'(dut.g_slot[0].u_slot.cnt_q), 0);
    // saturation
    action_pulse[0] = 1;
    for (int i = 0; i < 300; i++) begin
      action_param[0] = $urandom;
      tick();
    end
    check("sat_cnt", 32'(dut.g_slot[0].u_slot.cnt_q), 255);
    check("sat_cnt0", 32'(dut0.g_slot[0].u_slot.cnt_q), 255);
    idle(); ovr_clear = 1;
    tick();
    check("clr_cnt", 32'(dut.g_slot[0].u_slot.cnt_q), 0);
    idle();
    tick();
    check("clr_ovr", 32'(s1[16]), 0);
    ovr_clear = 1; action_pulse[0] = 1;
    tick();
    check("clr_race_cnt", 32'(dut.g_slot[0].u_slot.cnt_q), 1);
    idle();
    tick();
    check("clr_race_ovr", 32'(s1[16]), 1);
    // async reset mid-cycle with ch1 full
    action_pulse[1] = 1; action_param[1] = 32'hCAFE0001;
    tick();
    idle();
    check("pre_rst_v1", 32'(v1[1]), 1);
    #2 rst = 0;
    #1;
    model_reset();
    compare_all();
    check("rst_cnt_async", 32'(dut.g_slot[0].u_slot.cnt_q), 0);
    #1 rst = 1;
    tick();
    // soft clear beats pulses
    action_pulse = '1; action_param[0] = 32'h77;
    tick();
    soft_clr = 1; ovr_clear = 1; ch_ready = 4'b0101;
    tick();
    check("sclr_valid", 32'(v1), 0);
    check("sclr_cnt", 32'(dut.g_slot[0].u_slot.cnt_q), 0);
    idle();
    // random phase
    for (int i = 0; i < 600; i++) begin
      action_pulse = C'($urandom);
      ch_ready = C'($urandom);
      for (int c = 0; c < C; c++) action_param[c] = $urandom;
      ovr_clear = ($urandom_range(0, 15) == 0);
      soft_clr = ($urandom_range(0, 40) == 0);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
